// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter for the VGA path.
// Display scan-out has absolute priority for the single RAM port. Remaining
// cycles are shared round-robin between a write client and a read client.
// Scan-out pixels and read responses both appear two clocks after the access.
module vga_fb_arbiter #(
   parameter int HPOS_WIDTH  = 10,
   parameter int VPOS_WIDTH  = 10,
   parameter int SCALE_SHIFT = 2,
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_en,
   input  logic                  display_on,
   input  logic [HPOS_WIDTH-1:0] hpos,
   input  logic [VPOS_WIDTH-1:0] vpos,
   output logic [DATA_W-1:0]     pix_data,
   output logic                  pix_valid,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_resp_valid,
   output logic [DATA_W-1:0]     rd_resp_data,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam logic [31:0] FB_PIXELS = 32'(FB_W * FB_H);

   // Handshake: a client holds valid and its payload stable until it sees
   // ready in the same cycle; valid & ready is the transfer. Ready is a pure
   // combinational grant and never depends on anything but this cycle's
   // requests and the last_grant flop. Out-of-range transfers are accepted
   // but do not touch the RAM.

   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              wr_oob;
   logic              rd_oob;
   logic              wr_gnt;
   logic              rd_gnt;

   // last_wr_q = 1 means the write client won the most recent transfer
   logic              last_wr_q, last_wr_d;
   // stage 1: access issued last cycle, RAM data arrives this cycle
   logic              pix_s1_q, pix_s1_d;
   logic              pix_on_s1_q, pix_on_s1_d;
   logic              rd_s1_q, rd_s1_d;
   logic              rd_hit_s1_q, rd_hit_s1_d;
   // stage 2: registered outputs
   logic              pix_valid_q, pix_valid_d;
   logic [DATA_W-1:0] pix_data_q, pix_data_d;
   logic              rd_resp_valid_q, rd_resp_valid_d;
   logic [DATA_W-1:0] rd_resp_data_q, rd_resp_data_d;

   // Request decode: display request, scaled display address, range checks
   always_comb begin
      disp_req  = pix_en & display_on;
      disp_addr = ADDR_W'(32'(vpos >> SCALE_SHIFT) * 32'(FB_W)
                          + 32'(hpos >> SCALE_SHIFT));
      wr_oob    = 32'(wr_addr) >= FB_PIXELS;
      rd_oob    = 32'(rd_addr) >= FB_PIXELS;
   end

   // Client grant: display blocks both; on a tie the client not served last wins
   always_comb begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
      if (!disp_req) begin
         if (wr_valid && rd_valid) begin
            if (last_wr_q) rd_gnt = 1'b1;
            else           wr_gnt = 1'b1;
         end else begin
            wr_gnt = wr_valid;
            rd_gnt = rd_valid;
         end
      end
   end

   // RAM port drive: one access per cycle, address/data forced to 0 when idle
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (disp_req) begin
         mem_en   = 1'b1;
         mem_addr = disp_addr;
      end else if (wr_gnt && !wr_oob) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end else if (rd_gnt && !rd_oob) begin
         mem_en   = 1'b1;
         mem_addr = rd_addr;
      end
   end

   // Next-state: round-robin pointer and the two-stage response pipes
   always_comb begin
      last_wr_d = last_wr_q;
      if (wr_gnt)      last_wr_d = 1'b1;
      else if (rd_gnt) last_wr_d = 1'b0;

      pix_s1_d    = pix_en;
      pix_on_s1_d = disp_req;
      rd_s1_d     = rd_gnt;
      rd_hit_s1_d = rd_gnt & ~rd_oob;

      pix_valid_d = pix_s1_q;
      pix_data_d  = pix_data_q;
      if (pix_s1_q) pix_data_d = pix_on_s1_q ? mem_rdata : '0;

      rd_resp_valid_d = rd_s1_q;
      rd_resp_data_d  = rd_resp_data_q;
      if (rd_s1_q) rd_resp_data_d = rd_hit_s1_q ? mem_rdata : '0;
   end

   // State registers; reset drops anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_wr_q       <= 1'b0;
         pix_s1_q        <= 1'b0;
         pix_on_s1_q     <= 1'b0;
         rd_s1_q         <= 1'b0;
         rd_hit_s1_q     <= 1'b0;
         pix_valid_q     <= 1'b0;
         pix_data_q      <= '0;
         rd_resp_valid_q <= 1'b0;
         rd_resp_data_q  <= '0;
      end else begin
         last_wr_q       <= last_wr_d;
         pix_s1_q        <= pix_s1_d;
         pix_on_s1_q     <= pix_on_s1_d;
         rd_s1_q         <= rd_s1_d;
         rd_hit_s1_q     <= rd_hit_s1_d;
         pix_valid_q     <= pix_valid_d;
         pix_data_q      <= pix_data_d;
         rd_resp_valid_q <= rd_resp_valid_d;
         rd_resp_data_q  <= rd_resp_data_d;
      end
   end

   assign wr_ready      = wr_gnt;
   assign rd_ready      = rd_gnt;
   assign pix_valid     = pix_valid_q;
   assign pix_data      = pix_data_q;
   assign rd_resp_valid = rd_resp_valid_q;
   assign rd_resp_data  = rd_resp_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios followed by randomized traffic,
// with a framebuffer shadow model and response queues checked by a monitor.
module tb_vga_fb_arbiter;

   localparam int AW   = 15;
   localparam int DW   = 4;
   localparam int FBW  = 160;
   localparam int FBH  = 120;
   localparam int NPIX = FBW * FBH;

   logic          clk, rst;
   logic          pix_en, display_on;
   logic [9:0]    hpos, vpos;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_resp_valid;
   logic [DW-1:0] rd_resp_data;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   vga_fb_arbiter dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .display_on(display_on),
      .hpos(hpos), .vpos(vpos), .pix_data(pix_data), .pix_valid(pix_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM attached to the arbiter: synchronous, read data one cycle later
   bit [DW-1:0] ram [0:32767];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // reference model state
   bit [DW-1:0]   ref_mem [0:32767];
   bit            last_was_write;
   logic [DW-1:0] exp_pix_q[$];
   int            pix_due_q[$];
   logic [DW-1:0] exp_rd_q[$];
   int            rd_due_q[$];

   // staged stimulus
   logic          s_pix_en, s_disp_on;
   logic [9:0]    s_hpos, s_vpos;
   bit            wr_pend, rd_pend;
   logic [AW-1:0] wr_a, rd_a;
   logic [DW-1:0] wr_d;
   logic          seen_wr_ready;

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 15) == 0) return AW'(NPIX + $urandom_range(0, 100));
      return AW'($urandom_range(0, 7) * FBW + $urandom_range(0, 15));
   endfunction

   // driver: apply one cycle of stimulus, check RAM port and grants, update model
   task automatic step();
      int            daddr;
      bit            disp, gw, gr, w_oob, r_oob;
      logic          e_en, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      @(negedge clk);
      pix_en     = s_pix_en;
      display_on = s_disp_on;
      hpos       = s_hpos;
      vpos       = s_vpos;
      wr_valid   = wr_pend;
      wr_addr    = wr_a;
      wr_data    = wr_d;
      rd_valid   = rd_pend;
      rd_addr    = rd_a;
      #1;
      disp  = s_pix_en && s_disp_on;
      daddr = ((int'(s_vpos) / 4) * FBW + int'(s_hpos) / 4) % 32768;
      w_oob = int'(wr_a) >= NPIX;
      r_oob = int'(rd_a) >= NPIX;
      gw = 1'b0;
      gr = 1'b0;
      if (!disp) begin
         if (wr_pend && rd_pend) begin
            gw = !last_was_write;
            gr = last_was_write;
         end else begin
            gw = wr_pend;
            gr = rd_pend;
         end
      end
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (disp) begin
         e_en = 1'b1; e_addr = AW'(daddr);
      end else if (gw && !w_oob) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = wr_a; e_wd = wr_d;
      end else if (gr && !r_oob) begin
         e_en = 1'b1; e_addr = rd_a;
      end
      chk("wr_ready",  32'(wr_ready),  32'(gw));
      chk("rd_ready",  32'(rd_ready),  32'(gr));
      chk("mem_en",    32'(mem_en),    32'(e_en));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      seen_wr_ready = wr_ready;
      if (s_pix_en) begin
         exp_pix_q.push_back(s_disp_on ? ref_mem[daddr] : 4'h0);
         pix_due_q.push_back(cyc + 2);
      end
      if (gw) begin
         if (!w_oob) ref_mem[wr_a] = wr_d;
         last_was_write = 1'b1;
         wr_pend = 1'b0;
      end
      if (gr) begin
         exp_rd_q.push_back(r_oob ? 4'h0 : ref_mem[rd_a]);
         rd_due_q.push_back(cyc + 2);
         last_was_write = 1'b0;
         rd_pend = 1'b0;
      end
   endtask

   task automatic run_until_idle(input int bound);
      int n = 0;
      while ((wr_pend || rd_pend) && n < bound) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(wr_pend || rd_pend), 0);
   endtask

   // asserts reset a couple of ns after a rising edge, checks outputs clear
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      wr_pend = 1'b0; rd_pend = 1'b0; s_pix_en = 1'b0;
      pix_en = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
      #1;
      chk("rst_pix_valid",     32'(pix_valid),     0);
      chk("rst_pix_data",      32'(pix_data),      0);
      chk("rst_rd_resp_valid", 32'(rd_resp_valid), 0);
      chk("rst_rd_resp_data",  32'(rd_resp_data),  0);
      chk("rst_mem_en",        32'(mem_en),        0);
      exp_pix_q.delete(); pix_due_q.delete();
      exp_rd_q.delete();  rd_due_q.delete();
      last_was_write = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor / scoreboard: every strobe must match the head of its queue on time
   always @(negedge clk) begin
      if (!rst) begin
         if (pix_due_q.size() > 0 && pix_due_q[0] == cyc) begin
            chk("pix_valid", 32'(pix_valid), 1);
            chk("pix_data",  32'(pix_data),  32'(exp_pix_q[0]));
            void'(pix_due_q.pop_front());
            void'(exp_pix_q.pop_front());
         end else if (pix_valid) begin
            chk("pix_valid_unexpected", 32'(pix_valid), 0);
         end
         if (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
            chk("rd_resp_valid", 32'(rd_resp_valid), 1);
            chk("rd_resp_data",  32'(rd_resp_data),  32'(exp_rd_q[0]));
            void'(rd_due_q.pop_front());
            void'(exp_rd_q.pop_front());
         end else if (rd_resp_valid) begin
            chk("rd_resp_unexpected", 32'(rd_resp_valid), 0);
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit [3:0] tie_seen;
      rst = 1'b1;
      pix_en = 0; display_on = 0; hpos = 0; vpos = 0;
      wr_valid = 0; wr_addr = 0; wr_data = 0; rd_valid = 0; rd_addr = 0;
      s_pix_en = 0; s_disp_on = 0; s_hpos = 0; s_vpos = 0;
      wr_pend = 0; rd_pend = 0; wr_a = 0; wr_d = 0; rd_a = 0;
      last_was_write = 0;
      do_reset();

      // write 162 <- 0xA in blanking, then scan it out at hpos=9 vpos=5
      wr_pend = 1; wr_a = 15'd162; wr_d = 4'hA;
      step();
      chk("dir_write_ready", 32'(seen_wr_ready), 1);
      s_pix_en = 1; s_disp_on = 1; s_hpos = 10'd9; s_vpos = 10'd5;
      step();
      chk("dir_disp_addr", 32'(mem_addr), 162);
      s_pix_en = 0;
      repeat (3) step();

      // tie over four free cycles after reset: W,R,W,R
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (!wr_pend) begin wr_pend = 1; wr_a = rand_addr(); wr_d = 4'($urandom); end
         if (!rd_pend) begin rd_pend = 1; rd_a = rand_addr(); end
         step();
         tie_seen[k] = seen_wr_ready;
      end
      chk("tie_pattern", 32'(tie_seen), 32'h5);
      run_until_idle(8);
      repeat (3) step();

      // write held through display cycles
      wr_pend = 1; wr_a = 15'd5; wr_d = 4'h3;
      s_pix_en = 1; s_disp_on = 1;
      for (int k = 0; k < 3; k++) begin
         s_hpos = 10'(4 * k); s_vpos = 10'd0;
         step();
         chk("disp_blocks_wr", 32'(seen_wr_ready), 0);
      end
      s_pix_en = 0;
      step();
      chk("wr_after_disp", 32'(seen_wr_ready), 1);

      // blanking pixel: black, no RAM access
      s_pix_en = 1; s_disp_on = 0;
      step();
      chk("blank_no_mem_en", 32'(mem_en), 0);
      s_pix_en = 0;

      // out-of-range read and write
      rd_pend = 1; rd_a = 15'd19200;
      step();
      chk("oob_rd_ready", 32'(rd_ready), 1);
      chk("oob_rd_mem_en", 32'(mem_en), 0);
      wr_pend = 1; wr_a = 15'd19200; wr_d = 4'hF;
      step();
      chk("oob_wr_ready", 32'(wr_ready), 1);
      chk("oob_wr_mem_en", 32'(mem_en), 0);
      repeat (3) step();

      // reset one cycle after a read grant
      rd_pend = 1; rd_a = 15'd162;
      step();
      do_reset();
      repeat (3) step();
      wr_pend = 1; wr_a = 15'd7; wr_d = 4'h9;
      rd_pend = 1; rd_a = 15'd162;
      step();
      chk("post_rst_tie_write", 32'(seen_wr_ready), 1);
      run_until_idle(8);

      // randomized traffic: pix_en every cycle, every 2nd cycle, then random
      for (int i = 0; i < 1800; i++) begin
         case (i / 600)
            0:       s_pix_en = 1'b1;
            1:       s_pix_en = (i % 2) == 0;
            default: s_pix_en = 1'($urandom_range(0, 1));
         endcase
         s_disp_on = (i % 50) < 40;
         s_hpos = 10'($urandom_range(0, 63));
         s_vpos = 10'($urandom_range(0, 31));
         if (!wr_pend && $urandom_range(0, 2) == 0) begin
            wr_pend = 1; wr_a = rand_addr(); wr_d = 4'($urandom);
         end
         if (!rd_pend && $urandom_range(0, 2) == 0) begin
            rd_pend = 1; rd_a = rand_addr();
         end
         step();
      end

      // drain
      s_pix_en = 0;
      run_until_idle(50);
      repeat (4) step();
      chk("pix_queue_empty", 32'(exp_pix_q.size()), 0);
      chk("rd_queue_empty",  32'(exp_rd_q.size()),  0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
